// File: rtl/calc_pkg.sv
// Shared constants, encodings and small decode helpers for the calculator key controller.
package calc_pkg;

  localparam int VAL_W = 14;
  localparam int RES_W = 28;
  localparam int MAX_RESULT = 9999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_EQU = 4'hD;
  localparam logic [3:0] KEY_RSV = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_CALC    = 3'd2,
    ST_RESULT  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  function automatic logic isDigit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

  function automatic logic isOperator(input logic [3:0] key);
    return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
  endfunction

  function automatic op_t keyToOp(input logic [3:0] key);
    op_t op;
    case (key)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

  // Shifts one decimal digit into an operand; the wide intermediate avoids overflow before truncation.
  function automatic logic [VAL_W-1:0] appendDigit(input logic [VAL_W-1:0] val, input logic [3:0] digit);
    logic [VAL_W+3:0] tmp;
    tmp = {4'd0, val} * (VAL_W+4)'(10) + {{VAL_W{1'b0}}, digit};
    return tmp[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic core: add, subtract or multiply two operands and flag out-of-range results.
module calc_alu
  import calc_pkg::*;
(
  input  logic [VAL_W-1:0] a_i,
  input  logic [VAL_W-1:0] b_i,
  input  op_t              op_i,
  output logic [VAL_W-1:0] result_o,
  output logic             err_o
);

  logic [RES_W-1:0] aWide;
  logic [RES_W-1:0] bWide;
  logic [RES_W-1:0] fullRes;

  // Work at full width so a borrow shows up in the top bit and products never wrap.
  always_comb begin
    aWide = {{(RES_W-VAL_W){1'b0}}, a_i};
    bWide = {{(RES_W-VAL_W){1'b0}}, b_i};
    fullRes = '0;
    case (op_i)
      OP_ADD:  fullRes = aWide + bWide;
      OP_SUB:  fullRes = aWide - bWide;
      OP_MUL:  fullRes = aWide * bWide;
      default: fullRes = aWide + bWide;
    endcase
    err_o = fullRes[RES_W-1] || (fullRes > RES_W'(MAX_RESULT));
    result_o = err_o ? '0 : fullRes[VAL_W-1:0];
  end

endmodule

// File: rtl/calc_key_ctrl.sv
// Key-driven calculator controller: builds two decimal operands, applies an operator and registers the result.
module calc_key_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_flag,
  input  logic [3:0]  key_value,
  output logic [13:0] disp_value,
  output logic        disp_err,
  output logic        op_pending,
  output logic        result_valid
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] aVal_q, aVal_d;
  logic [VAL_W-1:0] bVal_q, bVal_d;
  logic [VAL_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] aCnt_q, aCnt_d;
  logic [CNT_W-1:0] bCnt_q, bCnt_d;
  op_t              opSel_q, opSel_d;

  logic [VAL_W-1:0] dispValue_q, dispValue_d;
  logic             dispErr_q, dispErr_d;
  logic             opPending_q, opPending_d;
  logic             resultValid_q, resultValid_d;

  logic [VAL_W-1:0] aluResult;
  logic             aluErr;

  calc_alu u_alu (
    .a_i      (aVal_q),
    .b_i      (bVal_q),
    .op_i     (opSel_q),
    .result_o (aluResult),
    .err_o    (aluErr)
  );

  // Next-state decode: one key event per cycle moves operands, operator and state; CALC ignores keys entirely.
  always_comb begin
    state_d       = state_q;
    aVal_d        = aVal_q;
    bVal_d        = bVal_q;
    result_d      = result_q;
    aCnt_d        = aCnt_q;
    bCnt_d        = bCnt_q;
    opSel_d       = opSel_q;
    resultValid_d = 1'b0;

    if (key_flag && (state_q != ST_CALC) && (key_value == KEY_CLR)) begin
      state_d  = ST_ENTER_A;
      aVal_d   = '0;
      bVal_d   = '0;
      result_d = '0;
      aCnt_d   = '0;
      bCnt_d   = '0;
      opSel_d  = OP_ADD;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (key_flag) begin
            if (isDigit(key_value)) begin
              if (aCnt_q < CNT_MAX) begin
                aVal_d = appendDigit(aVal_q, key_value);
                aCnt_d = aCnt_q + CNT_W'(1);
              end
            end else if (isOperator(key_value)) begin
              opSel_d = keyToOp(key_value);
              bVal_d  = '0;
              bCnt_d  = '0;
              state_d = ST_ENTER_B;
            end
          end
        end
        ST_ENTER_B: begin
          if (key_flag) begin
            if (isDigit(key_value)) begin
              if (bCnt_q < CNT_MAX) begin
                bVal_d = appendDigit(bVal_q, key_value);
                bCnt_d = bCnt_q + CNT_W'(1);
              end
            end else if (isOperator(key_value)) begin
              if (bCnt_q == '0) begin
                opSel_d = keyToOp(key_value);
              end
            end else if (key_value == KEY_EQU) begin
              if (bCnt_q != '0) begin
                state_d = ST_CALC;
              end
            end
          end
        end
        ST_CALC: begin
          state_d       = aluErr ? ST_ERROR : ST_RESULT;
          result_d      = aluResult;
          resultValid_d = 1'b1;
        end
        ST_RESULT: begin
          if (key_flag) begin
            if (isDigit(key_value)) begin
              aVal_d  = {{(VAL_W-4){1'b0}}, key_value};
              aCnt_d  = CNT_W'(1);
              state_d = ST_ENTER_A;
            end else if (isOperator(key_value)) begin
              aVal_d  = result_q;
              aCnt_d  = CNT_MAX;
              opSel_d = keyToOp(key_value);
              bVal_d  = '0;
              bCnt_d  = '0;
              state_d = ST_ENTER_B;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output decode from the next-state values so the registered outputs reflect a key one cycle after it.
  always_comb begin
    dispValue_d = '0;
    case (state_d)
      ST_ENTER_A: dispValue_d = aVal_d;
      ST_ENTER_B: dispValue_d = (bCnt_d != '0) ? bVal_d : aVal_d;
      ST_RESULT:  dispValue_d = result_d;
      default:    dispValue_d = '0;
    endcase
    dispErr_d   = (state_d == ST_ERROR);
    opPending_d = (state_d == ST_ENTER_B);
  end

  // State, datapath and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ENTER_A;
      aVal_q        <= '0;
      bVal_q        <= '0;
      result_q      <= '0;
      aCnt_q        <= '0;
      bCnt_q        <= '0;
      opSel_q       <= OP_ADD;
      dispValue_q   <= '0;
      dispErr_q     <= 1'b0;
      opPending_q   <= 1'b0;
      resultValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aVal_q        <= aVal_d;
      bVal_q        <= bVal_d;
      result_q      <= result_d;
      aCnt_q        <= aCnt_d;
      bCnt_q        <= bCnt_d;
      opSel_q       <= opSel_d;
      dispValue_q   <= dispValue_d;
      dispErr_q     <= dispErr_d;
      opPending_q   <= opPending_d;
      resultValid_q <= resultValid_d;
    end
  end

  assign disp_value   = dispValue_q;
  assign disp_err     = dispErr_q;
  assign op_pending   = opPending_q;
  assign result_valid = resultValid_q;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Self-checking bench for calc_key_ctrl: directed key sequences followed by random keys against a behavioural model.
module tb_calc_key_ctrl;

  localparam int MAXD = 4;

  localparam int M_A   = 0;
  localparam int M_B   = 1;
  localparam int M_RES = 2;
  localparam int M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        keyFlag = 1'b0;
  logic [3:0]  keyValue = 4'd0;
  logic [13:0] dispValue;
  logic        dispErr;
  logic        opPending;
  logic        resultValid;

  int vecCount = 0;
  int missCount = 0;

  int mMode = M_A;
  int mA = 0;
  int mB = 0;
  int mNa = 0;
  int mNb = 0;
  int mOp = 0;
  int mRes = 0;

  calc_key_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_flag     (keyFlag),
    .key_value    (keyValue),
    .disp_value   (dispValue),
    .disp_err     (dispErr),
    .op_pending   (opPending),
    .result_valid (resultValid)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  task automatic modelReset();
    mMode = M_A;
    mA = 0;
    mB = 0;
    mNa = 0;
    mNb = 0;
    mOp = 0;
    mRes = 0;
  endtask

  function automatic int modelDisp();
    case (mMode)
      M_A:     return mA;
      M_B:     return (mNb > 0) ? mB : mA;
      M_RES:   return mRes;
      default: return 0;
    endcase
  endfunction

  // Calculator behaviour expressed as plain integer arithmetic; startsCalc marks an accepted equals.
  task automatic modelKey(input int k, output bit startsCalc);
    int r;
    startsCalc = 1'b0;
    if (k == 15) begin
      modelReset();
      return;
    end
    if (k == 14) return;
    case (mMode)
      M_A: begin
        if (k < 10) begin
          if (mNa < MAXD) begin
            mA = mA * 10 + k;
            mNa++;
          end
        end else if (k <= 12) begin
          mOp = k;
          mB = 0;
          mNb = 0;
          mMode = M_B;
        end
      end
      M_B: begin
        if (k < 10) begin
          if (mNb < MAXD) begin
            mB = mB * 10 + k;
            mNb++;
          end
        end else if (k <= 12) begin
          if (mNb == 0) mOp = k;
        end else if (mNb > 0) begin
          startsCalc = 1'b1;
          if (mOp == 10) r = mA + mB;
          else if (mOp == 11) r = mA - mB;
          else r = mA * mB;
          if (r < 0 || r > 9999) begin
            mMode = M_ERR;
            mRes = 0;
          end else begin
            mMode = M_RES;
            mRes = r;
          end
        end
      end
      M_RES: begin
        if (k < 10) begin
          mA = k;
          mNa = 1;
          mMode = M_A;
        end else if (k <= 12) begin
          mA = mRes;
          mNa = MAXD;
          mOp = k;
          mB = 0;
          mNb = 0;
          mMode = M_B;
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input int eDisp, input bit eErr, input bit ePend, input bit eRv);
    vecCount++;
    assert (dispValue === 14'(eDisp)) else begin
      missCount++;
      $error("[TB] FAIL %s disp_value observed=%0d expected=%0d", tag, dispValue, eDisp);
    end
    vecCount++;
    assert (dispErr === eErr) else begin
      missCount++;
      $error("[TB] FAIL %s disp_err observed=%b expected=%b", tag, dispErr, eErr);
    end
    vecCount++;
    assert (opPending === ePend) else begin
      missCount++;
      $error("[TB] FAIL %s op_pending observed=%b expected=%b", tag, opPending, ePend);
    end
    vecCount++;
    assert (resultValid === eRv) else begin
      missCount++;
      $error("[TB] FAIL %s result_valid observed=%b expected=%b", tag, resultValid, eRv);
    end
  endtask

  // One key strobe, then check the cycle after it and the cycle after that against the model.
  task automatic applyStimulus(input int k);
    bit calc;
    @(negedge clk);
    keyFlag = 1'b1;
    keyValue = 4'(k);
    modelKey(k, calc);
    @(negedge clk);
    keyFlag = 1'b0;
    keyValue = 4'($urandom_range(0, 15));
    if (calc) checkOutput("calcCycle", 0, 1'b0, 1'b0, 1'b0);
    else checkOutput("keyCycle", modelDisp(), mMode == M_ERR, mMode == M_B, 1'b0);
    @(negedge clk);
    checkOutput("settled", modelDisp(), mMode == M_ERR, mMode == M_B, calc);
  endtask

  task automatic pressSeq(input string seq);
    byte c;
    for (int i = 0; i < seq.len(); i++) begin
      c = seq[i];
      if (c >= "A") applyStimulus(int'(c - "A") + 10);
      else applyStimulus(int'(c - "0"));
    end
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("resetState", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    pressSeq("12A34D");
    checkOutput("add12p34", 46, 1'b0, 1'b0, 1'b1);

    pressSeq("F99C99D");
    checkOutput("mul99x99", 9801, 1'b0, 1'b0, 1'b1);
    pressSeq("A99D");
    checkOutput("chain9900", 9900, 1'b0, 1'b0, 1'b1);
    pressSeq("C2D");
    checkOutput("mulOverflow", 0, 1'b1, 1'b0, 1'b1);
    pressSeq("F");

    pressSeq("5B7D");
    checkOutput("subNegative", 0, 1'b1, 1'b0, 1'b1);
    pressSeq("3");
    checkOutput("errIgnoresDigit", 0, 1'b1, 1'b0, 1'b0);
    pressSeq("F");
    checkOutput("clearFromErr", 0, 1'b0, 1'b0, 1'b0);

    pressSeq("12345");
    checkOutput("digitLimit", 1234, 1'b0, 1'b0, 1'b0);
    pressSeq("AAB6D");
    checkOutput("opReplace", 1228, 1'b0, 1'b0, 1'b1);

    pressSeq("F12A3D");
    checkOutput("add12p3", 15, 1'b0, 1'b0, 1'b1);
    pressSeq("A5D");
    checkOutput("chain15p5", 20, 1'b0, 1'b0, 1'b1);
    pressSeq("F42ED");
    checkOutput("eqRsvIgnored", 42, 1'b0, 1'b0, 1'b0);

    pressSeq("F1A7");
    checkOutput("enterB7", 7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("asyncReset", 0, 1'b0, 1'b0, 1'b0);
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("heldReset", 0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    pressSeq("D");
    checkOutput("afterResetEq", 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if (k == 15 && $urandom_range(0, 3) != 0) k = $urandom_range(0, 9);
      applyStimulus(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
